// File: rtl/call_attendant_panel_pkg.sv
// Shared definitions for the attendant call panel: FSM state encoding,
// a constant-safe ceiling log2 helper and the default seat-index width.
package call_attendant_panel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_CANCEL  = 2'd2,
        ST_RELEASE = 2'd3
    } panel_state_t;

    // Ceiling log2, never below 1 so a 2-seat panel still gets a 1-bit index
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_SEATS  = 4;
    localparam int DEFAULT_SEAT_W = clog2(DEFAULT_SEATS);

endpackage

// File: rtl/call_attendant_panel_rr_arbiter.sv
// Combinational round-robin winner search. The search starts one seat
// after the pointer and wraps, so the seat named by the pointer (the one
// served last) has the lowest priority.
module call_rr_arbiter
    import call_attendant_panel_pkg::*;
#(
    parameter  int N_SEATS = DEFAULT_SEATS,
    localparam int SEAT_W  = clog2(N_SEATS)
) (
    input  logic [N_SEATS-1:0] req,
    input  logic [SEAT_W-1:0]  ptr,
    output logic [SEAT_W-1:0]  grant,
    output logic               any_req
);

    int                cand;
    logic [SEAT_W-1:0] cand_idx;

    // Walk the seats from ptr+1 around to ptr and keep the first lit one
    always_comb begin
        grant    = ptr;
        any_req  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= N_SEATS; off++) begin
            cand     = (int'(ptr) + off) % N_SEATS;
            cand_idx = SEAT_W'(cand);
            if (!any_req && req[cand_idx]) begin
                grant   = cand_idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_attendant_panel.sv
// Attendant-side call panel. Picks one lit seat round-robin, shows it to
// the attendant and, on an ack press, holds that seat's cancel line until
// its light clears (or gives up after CANCEL_MAX cycles and flags stuck).
// Optional feature macro: CALL_TIMEOUT_EN enables the SERVE wait counter
// and the escalate output; without it escalate is tied low.
module call_attendant_panel
    import call_attendant_panel_pkg::*;
#(
    parameter  int N_SEATS    = DEFAULT_SEATS,
    parameter  int CANCEL_MAX = 8,
    parameter  int TIMEOUT    = 64,
    localparam int SEAT_W     = clog2(N_SEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SEATS-1:0] light_state,
    input  logic               ack,
    output logic [N_SEATS-1:0] cancel,
    output logic               seat_valid,
    output logic [SEAT_W-1:0]  seat_idx,
    output logic [SEAT_W:0]    pending,
    output logic               stuck,
    output logic               escalate
);

    localparam int CW = clog2(CANCEL_MAX + 1);

    panel_state_t       state;
    panel_state_t       state_next;

    logic [N_SEATS-1:0] light_q;
    logic               ack_q;
    logic               ack_rise;
    logic [SEAT_W-1:0]  rr_ptr;
    logic [SEAT_W-1:0]  grant;
    logic               any_req;
    logic [CW-1:0]      cancel_cnt;
    logic               cancel_expired;
    logic               seat_lit;
    logic [SEAT_W:0]    lit_count;

    // A held ack button counts as a single press
    assign ack_rise       = ack & ~ack_q;
    assign seat_lit       = light_state[seat_idx];
    assign cancel_expired = (cancel_cnt == CW'(CANCEL_MAX - 1));

    // The arbiter looks at the registered lights, giving two edges from a
    // seat lighting up to it being shown to the attendant
    call_rr_arbiter #(
        .N_SEATS (N_SEATS)
    ) u_arbiter (
        .req     (light_q),
        .ptr     (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    // Count lit seats for the pending display
    always_comb begin
        lit_count = '0;
        for (int i = 0; i < N_SEATS; i++) begin
            lit_count = lit_count + {{SEAT_W{1'b0}}, light_state[i]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a self-cancel in SERVE wins over a same-cycle ack
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!seat_lit) begin
                    state_next = ST_IDLE;
                end else if (ack_rise) begin
                    state_next = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (!seat_lit || cancel_expired) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: input sampling, selected seat, pointer, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_q    <= '0;
            ack_q      <= 1'b0;
            pending    <= '0;
            seat_idx   <= '0;
            rr_ptr     <= SEAT_W'(N_SEATS - 1);
            cancel_cnt <= '0;
            stuck      <= 1'b0;
        end else begin
            light_q <= light_state;
            ack_q   <= ack;
            pending <= lit_count;
            if (state == ST_IDLE && any_req) begin
                seat_idx <= grant;
            end
            if (state == ST_RELEASE) begin
                rr_ptr <= seat_idx;
            end
            if (state == ST_CANCEL) begin
                cancel_cnt <= cancel_cnt + 1'b1;
            end else begin
                cancel_cnt <= '0;
            end
            if (state == ST_CANCEL && seat_lit && cancel_expired) begin
                stuck <= 1'b1;
            end
        end
    end

`ifdef CALL_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Saturating count of cycles spent waiting for the attendant in SERVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_SERVE) begin
            if (wait_cnt != TW'(TIMEOUT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // Outputs decoded from state so an async reset drops cancel immediately
    always_comb begin
        cancel     = '0;
        seat_valid = (state == ST_SERVE) || (state == ST_CANCEL);
        if (state == ST_CANCEL) begin
            cancel[seat_idx] = 1'b1;
        end
`ifdef CALL_TIMEOUT_EN
        escalate = (state == ST_SERVE) && (wait_cnt >= TW'(TIMEOUT));
`else
        escalate = 1'b0;
`endif
    end

endmodule

// File: tb/tb_call_attendant_panel.sv
// Directed self-checking bench for call_attendant_panel with N_SEATS=4,
// CANCEL_MAX=8, TIMEOUT=16. Expected escalate behaviour follows the
// CALL_TIMEOUT_EN macro.
module tb_call_attendant_panel;

    logic       clk;
    logic       rst_n;
    logic [3:0] light_state;
    logic       ack;
    logic [3:0] cancel;
    logic       seat_valid;
    logic [1:0] seat_idx;
    logic [2:0] pending;
    logic       stuck;
    logic       escalate;

    int assert_count;
    int fail_count;

    call_attendant_panel #(
        .N_SEATS    (4),
        .CANCEL_MAX (8),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .light_state (light_state),
        .ack         (ack),
        .cancel      (cancel),
        .seat_valid  (seat_valid),
        .seat_idx    (seat_idx),
        .pending     (pending),
        .stuck       (stuck),
        .escalate    (escalate)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] lights, input logic button);
        light_state = lights;
        ack         = button;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetDut(input logic [3:0] lights);
        rst_n = 1'b0;
        applyStimulus(lights, 1'b0);
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic waitValid(input string tag);
        int k;
        k = 0;
        while (!seat_valid && k < 10) begin
            step(1);
            k++;
        end
        checkOutput(tag, seat_valid, 1'b1);
    endtask

    // Serve one seat acting as the seat model: drop the light on cancel, relight after
    task automatic serveSeat(input logic [1:0] exp_seat);
        logic [3:0] onehot;
        onehot = 4'b0001 << exp_seat;
        waitValid("rr_valid");
        checkOutput("rr_seat", seat_idx, exp_seat);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checkOutput("rr_cancel", cancel, onehot);
        light_state = light_state & ~onehot;
        step(1);
        checkOutput("rr_cancel_drop", cancel, 4'b0000);
        light_state = light_state | onehot;
    endtask

    initial begin
        int held;
        logic exp_esc;
        assert_count = 0;
        fail_count   = 0;
        applyStimulus(4'b0000, 1'b0);

        // Reset with all lights lit
        rst_n = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        step(3);
        checkOutput("rst_cancel", cancel, 4'b0000);
        checkOutput("rst_valid", seat_valid, 1'b0);
        checkOutput("rst_idx", seat_idx, 2'd0);
        checkOutput("rst_pending", pending, 3'd0);
        checkOutput("rst_stuck", stuck, 1'b0);
        checkOutput("rst_escalate", escalate, 1'b0);
        rst_n = 1'b1;
        step(1);
        checkOutput("rel_valid_e1", seat_valid, 1'b0);
        checkOutput("rel_pending", pending, 3'd4);
        step(1);
        checkOutput("rel_valid_e2", seat_valid, 1'b1);
        checkOutput("rel_idx", seat_idx, 2'd0);

        // Single call on seat 2
        resetDut(4'b0100);
        step(2);
        checkOutput("single_valid", seat_valid, 1'b1);
        checkOutput("single_idx", seat_idx, 2'd2);
        checkOutput("single_no_cancel", cancel, 4'b0000);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checkOutput("single_cancel", cancel, 4'b0100);
        light_state = 4'b0000;
        step(1);
        checkOutput("single_cancel_drop", cancel, 4'b0000);
        checkOutput("single_valid_drop", seat_valid, 1'b0);
        step(1);
        checkOutput("single_idle_valid", seat_valid, 1'b0);

        // Round-robin over seats 0,1,3
        resetDut(4'b1011);
        step(2);
        checkOutput("rr_pending", pending, 3'd3);
        serveSeat(2'd0);
        serveSeat(2'd1);
        serveSeat(2'd3);
        serveSeat(2'd0);

        // Seat 2 never drops its light
        resetDut(4'b1100);
        step(2);
        checkOutput("stuck_idx", seat_idx, 2'd2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        held = 0;
        while (cancel == 4'b0100 && held < 20) begin
            held++;
            step(1);
        end
        checkOutput("stuck_hold_cycles", held, 8);
        checkOutput("stuck_flag", stuck, 1'b1);
        checkOutput("stuck_cancel_low", cancel, 4'b0000);
        waitValid("stuck_next_valid");
        checkOutput("stuck_next_idx", seat_idx, 2'd3);

        // Async reset mid-CANCEL drops cancel without a clock edge and clears stuck
        resetDut(4'b0001);
        checkOutput("reset_clears_stuck", stuck, 1'b0);
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checkOutput("async_cancel_on", cancel, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_cancel_off", cancel, 4'b0000);
        step(1);
        rst_n = 1'b1;

        // Seat 1 cancels itself before ack; later ack in IDLE does nothing
        resetDut(4'b0010);
        step(2);
        checkOutput("self_valid", seat_valid, 1'b1);
        checkOutput("self_idx", seat_idx, 2'd1);
        applyStimulus(4'b0000, 1'b0);
        step(1);
        checkOutput("self_valid_drop", seat_valid, 1'b0);
        checkOutput("self_no_cancel", cancel, 4'b0000);
        step(1);
        ack = 1'b1;
        step(1);
        checkOutput("idle_ack_cancel", cancel, 4'b0000);
        checkOutput("idle_ack_valid", seat_valid, 1'b0);
        ack = 1'b0;
        step(1);
        checkOutput("idle_ack_cancel2", cancel, 4'b0000);

        // Seat 0 left waiting in SERVE
`ifdef CALL_TIMEOUT_EN
        exp_esc = 1'b1;
`else
        exp_esc = 1'b0;
`endif
        resetDut(4'b0001);
        step(2);
        checkOutput("wait_valid", seat_valid, 1'b1);
        step(15);
        checkOutput("wait_escalate_15", escalate, 1'b0);
        step(1);
        checkOutput("wait_escalate_16", escalate, exp_esc);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checkOutput("wait_escalate_ack", escalate, 1'b0);
        checkOutput("wait_cancel", cancel, 4'b0001);
        light_state = 4'b0000;
        step(1);
        checkOutput("wait_cancel_drop", cancel, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
